pad_input_conditioner: RTL and testbench
========================================

Name: pad_input_conditioner

Overview:
- Input-direction counterpart to the pad-ring output gating. Takes raw bidir pad Y levels, synchronises them into the core clock domain, glitch-filters each pin and detects edges.
- Edge events are held as sticky per-pin pending bits with write-1-to-clear, plus one aggregated interrupt.
- Sits between the bidir pad instances' Y outputs and the core's GPIO/peripheral logic. Uses the same clock and reset as the core.

Parameters:
- NUM_PINS, 40, number of conditioned pad inputs.
- SYNC_STAGES, 2, synchroniser flops per pin; legal values 2..4.
- FILT_W, 4, width of filt_len and of each per-pin stability counter.

Ports:
- clk  input  1  core clock, the pad clock after the input buffer.
- rst_n  input  1  asynchronous active-low reset; already synchronised for deassertion upstream.
- pad_in  input  NUM_PINS  raw pad Y levels, asynchronous to clk.
- filt_len  input  FILT_W  required consecutive stable cycles; quasi-static.
- rise_en  input  NUM_PINS  per-pin rising-edge event enable.
- fall_en  input  NUM_PINS  per-pin falling-edge event enable.
- evt_clr  input  NUM_PINS  write-1-to-clear pulse for evt_pending.
- pin_out  output  NUM_PINS  filtered, synchronised level.
- evt_pending  output  NUM_PINS  sticky edge-event flags.
- irq  output  1  registered OR of evt_pending.

Behaviour:
- Reset (async, rst_n=0): all synchroniser flops=0, counters=0, pin_out=0, evt_pending=0, irq=0.
- Synchroniser: per pin, a chain of SYNC_STAGES flops. The last stage is s[i].
- No logic may sit between the synchroniser flops.
- Effective length L = max(filt_len,1); filt_len=0 behaves as 1.
- Filter, per pin:
  - s==pin_out: cnt<=0.
  - s!=pin_out and cnt+1>=L: pin_out<=s, cnt<=0 (this is the flip condition).
  - Otherwise cnt<=cnt+1.
  - cnt never exceeds L-1, so no overflow handling is needed.
  - A mismatch that ends before L cycles leaves pin_out unchanged and clears cnt.
- Latency: a pad level stable from cycle 0 appears on pin_out after exactly SYNC_STAGES+L clock edges.
- Edge detect: evaluated on the flip condition itself, in the same edge that updates pin_out.
  - rise = flip & s; fall = flip & ~s.
- evt_pending[i] next-state:
  - Set if (rise&rise_en)|(fall&fall_en).
  - Else clear if evt_clr[i].
  - Else hold.
  - Set and clear in the same cycle: set wins and the bit stays 1.
  - evt_clr on a 0 bit has no effect.
- irq <= |evt_pending, one cycle after the pending update, so the first event reaches irq at SYNC_STAGES+L+1 edges.
- Enables are sampled only at the flip edge. Disabling an enable does not clear an already-set pending bit.
- filt_len change mid-count takes effect immediately via the >= compare; a counter already at or above the new L-1 flips on the next mismatch cycle.
- Pin held high through reset release: pin_out rises after SYNC_STAGES+L cycles and a rising event is raised if rise_en is set. This is intentional; software clears it at init.
- Reset asserted mid-count or mid-flip: everything returns to reset values immediately.
- Outputs are glitch-free registered values; no combinational path from any input to any output.

Decomposition:
- Package pad_cond_pkg holds:
  - Defaults for NUM_PINS, SYNC_STAGES and FILT_W.
  - The localparam rule L=max(filt_len,1), provided as a function.
  - typedef edge_evt_t as a 2-bit struct {rise, fall}.
- Sub-module pad_in_filter contains one pin's synchroniser, counter, pin_out flop and edge outputs. It is instantiated NUM_PINS times in a generate loop.
- The top level holds evt_pending, the clear logic and irq.

Test Plan:
- filt_len=3, SYNC_STAGES=2, rise_en[5]=1; pad_in[5] 0→1 at cycle 10 and held -> pin_out[5]=1 at edge 15, evt_pending[5]=1 at edge 15, irq=1 at edge 16.
- filt_len=4; pad_in[0] high pulse 3 cycles wide -> pin_out[0] stays 0, no event. Pulse of 4 cycles -> pin_out[0] rises at edge +6 and falls 6 edges after pad_in[0] falls.
- filt_len=0 vs filt_len=1 -> identical traces; pad_in[2] change visible on pin_out 3 edges later.
- Event pending on pin 7; evt_clr[7]=1 in the same cycle as a new fall event with fall_en[7]=1 -> evt_pending[7] stays 1. A clear in a later idle cycle -> 0, and irq drops 1 cycle after that.
- rise_en=0, fall_en[9]=1; square wave on pin 9 with period 20, filt_len=2 -> pin_out tracks it; pending is set only on falling flips; rising flips leave pending unchanged.
- All pads high; rst_n asserted for 5 cycles, then released -> outputs 0 during reset; pin_out all ones at SYNC_STAGES+L edges after release; rising events on pins with rise_en set. rst_n re-asserted mid-count clears pin_out and cnt asynchronously.

Source files
------------

// File: rtl/pad_cond_pkg.sv
// Shared types, default sizes and the filter-length rule for the pad input conditioner.
package pad_cond_pkg;

  localparam int NUM_PINS_DEF    = 40;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_W_DEF      = 4;

  // One pin's edge events, valid in the cycle the filtered level flips.
  typedef struct packed {
    logic rise;
    logic fall;
  } edge_evt_t;

  // A programmed filter length of zero is treated as one, so a change
  // still needs one stable cycle past the synchroniser.
  function automatic int unsigned eff_len(input int unsigned len);
    return (len == 0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/pad_in_filter.sv
// One pad input: synchroniser chain, stability counter, filtered level flop
// and edge events generated on the flip condition.
module pad_in_filter
  import pad_cond_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,  // legal range 2..4
  parameter int FILT_W      = FILT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pad,
  input  logic [FILT_W-1:0] filt_len,
  output logic              level,
  output edge_evt_t         evt
);

  localparam logic [FILT_W-1:0] CNT_ONE = FILT_W'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic [FILT_W-1:0]      cnt;
  logic                   s;
  logic                   flip;
  int unsigned            len_eff;
  int unsigned            cnt_inc;

  // Plain flop chain into the clock domain; nothing sits between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pad};
    end
  end

  // Flip when the synchronised level has disagreed with the filtered level
  // for the effective length; compared wide so cnt+1 cannot wrap.
  always_comb begin
    s       = sync[SYNC_STAGES-1];
    len_eff = eff_len(32'(filt_len));
    cnt_inc = 32'(cnt) + 32'd1;
    flip    = (s != level) && (cnt_inc >= len_eff);
    evt     = '0;
    evt.rise = flip & s;
    evt.fall = flip & ~s;
  end

  // Stability counter and filtered level; any agreement resets the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (s == level) begin
      cnt <= '0;
    end else if (flip) begin
      level <= s;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/pad_input_conditioner.sv
// Conditions raw pad Y levels: per-pin synchronise and glitch filter, sticky
// write-1-to-clear edge pending bits and one registered interrupt.
module pad_input_conditioner
  import pad_cond_pkg::*;
#(
  parameter int NUM_PINS    = NUM_PINS_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_W      = FILT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_PINS-1:0] pad_in,
  input  logic [FILT_W-1:0]   filt_len,
  input  logic [NUM_PINS-1:0] rise_en,
  input  logic [NUM_PINS-1:0] fall_en,
  input  logic [NUM_PINS-1:0] evt_clr,
  output logic [NUM_PINS-1:0] pin_out,
  output logic [NUM_PINS-1:0] evt_pending,
  output logic                irq
);

  logic [NUM_PINS-1:0] rise;
  logic [NUM_PINS-1:0] fall;
  logic [NUM_PINS-1:0] set_mask;

  for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_pin
    edge_evt_t evt;

    pad_in_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_W     (FILT_W)
    ) u_filter (
      .clk     (clk),
      .rst_n   (rst_n),
      .pad     (pad_in[gi]),
      .filt_len(filt_len),
      .level   (pin_out[gi]),
      .evt     (evt)
    );

    assign rise[gi] = evt.rise;
    assign fall[gi] = evt.fall;
  end

  assign set_mask = (rise & rise_en) | (fall & fall_en);

  // Sticky pending bits; a new event beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_pending <= '0;
    end else begin
      evt_pending <= set_mask | (evt_pending & ~evt_clr);
    end
  end

  // Interrupt follows the pending register one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |evt_pending;
    end
  end

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Directed bench for pad_input_conditioner: latency, glitch rejection,
// zero-length filter, pending set/clear priority, fall-only events, reset.
module tb_pad_input_conditioner;

  localparam int NUM_PINS = 40;
  localparam int FILT_W   = 4;

  localparam logic [NUM_PINS-1:0] PIN0  = 40'd1 << 0;
  localparam logic [NUM_PINS-1:0] PIN5  = 40'd1 << 5;
  localparam logic [NUM_PINS-1:0] PIN7  = 40'd1 << 7;
  localparam logic [NUM_PINS-1:0] PIN9  = 40'd1 << 9;
  localparam logic [NUM_PINS-1:0] RMASK = 40'hA5_0000_0C03;
  localparam logic [NUM_PINS-1:0] ONES  = '1;

  logic                clk;
  logic                rst_n;
  logic [NUM_PINS-1:0] pad_in;
  logic [FILT_W-1:0]   filt_len;
  logic [NUM_PINS-1:0] rise_en;
  logic [NUM_PINS-1:0] fall_en;
  logic [NUM_PINS-1:0] evt_clr;
  logic [NUM_PINS-1:0] pin_out;
  logic [NUM_PINS-1:0] evt_pending;
  logic                irq;

  int vectors;
  int miscompares;

  pad_input_conditioner #(
    .NUM_PINS   (NUM_PINS),
    .SYNC_STAGES(2),
    .FILT_W     (FILT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pad_in     (pad_in),
    .filt_len   (filt_len),
    .rise_en    (rise_en),
    .fall_en    (fall_en),
    .evt_clr    (evt_clr),
    .pin_out    (pin_out),
    .evt_pending(evt_pending),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n    = 1'b0;
    pad_in   = '0;
    filt_len = 4'd3;
    rise_en  = '0;
    fall_en  = '0;
    evt_clr  = '0;

    tick(2);
    check("reset_pin_out", 64'(pin_out), 64'd0);
    check("reset_pending", 64'(evt_pending), 64'd0);
    check("reset_irq", 64'(irq), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Rising event on pin 5, filt_len=3: flip 5 edges later, irq one after.
    rise_en = PIN5;
    pad_in[5] = 1'b1;
    tick(4);
    check("t1_pin5_before", 64'(pin_out[5]), 64'd0);
    tick(1);
    check("t1_pin5_flip", 64'(pin_out[5]), 64'd1);
    check("t1_pend_set", 64'(evt_pending), 64'(PIN5));
    check("t1_irq_lag", 64'(irq), 64'd0);
    tick(1);
    check("t1_irq_set", 64'(irq), 64'd1);
    evt_clr = PIN5;
    tick(1);
    evt_clr = '0;
    check("t1_pend_clr", 64'(evt_pending), 64'd0);
    check("t1_irq_hold", 64'(irq), 64'd1);
    tick(1);
    check("t1_irq_drop", 64'(irq), 64'd0);
    rise_en = '0;

    // filt_len=4: 3-cycle pulse rejected, 4-cycle pulse passes.
    filt_len = 4'd4;
    rise_en  = PIN0;
    pad_in[0] = 1'b1;
    tick(3);
    pad_in[0] = 1'b0;
    tick(8);
    check("t2_short_pin0", 64'(pin_out[0]), 64'd0);
    check("t2_short_pend", 64'(evt_pending), 64'd0);
    pad_in[0] = 1'b1;
    tick(4);
    pad_in[0] = 1'b0;
    tick(1);
    check("t2_long_pin0_e5", 64'(pin_out[0]), 64'd0);
    tick(1);
    check("t2_long_pin0_e6", 64'(pin_out[0]), 64'd1);
    check("t2_long_pend", 64'(evt_pending), 64'(PIN0));
    tick(3);
    check("t2_fall_e9", 64'(pin_out[0]), 64'd1);
    tick(1);
    check("t2_fall_e10", 64'(pin_out[0]), 64'd0);
    check("t2_fall_no_evt", 64'(evt_pending), 64'(PIN0));
    evt_clr = PIN0;
    tick(1);
    evt_clr = '0;
    rise_en = '0;
    check("t2_pend_clr", 64'(evt_pending), 64'd0);

    // filt_len 0 and 1 both give 3-edge latency.
    filt_len = 4'd0;
    pad_in[2] = 1'b1;
    tick(2);
    check("t3_len0_e2", 64'(pin_out[2]), 64'd0);
    tick(1);
    check("t3_len0_e3", 64'(pin_out[2]), 64'd1);
    filt_len = 4'd1;
    pad_in[2] = 1'b0;
    tick(2);
    check("t3_len1_e2", 64'(pin_out[2]), 64'd1);
    tick(1);
    check("t3_len1_e3", 64'(pin_out[2]), 64'd0);

    // Pin 7: clear coinciding with a new fall event loses; later clear wins.
    rise_en = PIN7;
    fall_en = PIN7;
    pad_in[7] = 1'b1;
    tick(3);
    check("t4_pin7_rise", 64'(pin_out[7]), 64'd1);
    check("t4_pend_rise", 64'(evt_pending), 64'(PIN7));
    pad_in[7] = 1'b0;
    tick(2);
    evt_clr = PIN7;
    tick(1);
    evt_clr = '0;
    check("t4_pin7_fall", 64'(pin_out[7]), 64'd0);
    check("t4_set_wins", 64'(evt_pending), 64'(PIN7));
    tick(1);
    evt_clr = PIN7;
    tick(1);
    evt_clr = '0;
    check("t4_idle_clr", 64'(evt_pending), 64'd0);
    check("t4_irq_hold", 64'(irq), 64'd1);
    tick(1);
    check("t4_irq_drop", 64'(irq), 64'd0);
    rise_en = '0;
    fall_en = '0;

    // Pin 9 square wave, period 20, filt_len=2: only falls set pending.
    filt_len = 4'd2;
    fall_en  = PIN9;
    pad_in[9] = 1'b1;
    tick(3);
    check("t5_rise_e3", 64'(pin_out[9]), 64'd0);
    tick(1);
    check("t5_rise_e4", 64'(pin_out[9]), 64'd1);
    check("t5_rise_no_evt", 64'(evt_pending), 64'd0);
    tick(6);
    pad_in[9] = 1'b0;
    tick(4);
    check("t5_fall1", 64'(pin_out[9]), 64'd0);
    check("t5_fall1_evt", 64'(evt_pending), 64'(PIN9));
    tick(6);
    pad_in[9] = 1'b1;
    tick(4);
    check("t5_rise2", 64'(pin_out[9]), 64'd1);
    check("t5_rise2_pend", 64'(evt_pending), 64'(PIN9));
    tick(6);
    pad_in[9] = 1'b0;
    tick(4);
    check("t5_fall2", 64'(pin_out[9]), 64'd0);
    evt_clr = PIN9;
    tick(1);
    evt_clr = '0;
    check("t5_pend_clr", 64'(evt_pending), 64'd0);
    fall_en = '0;

    // All pads high through reset; release; then reset mid-count.
    filt_len = 4'd3;
    rise_en  = RMASK;
    rst_n    = 1'b0;
    pad_in   = ONES;
    tick(5);
    check("t6_rst_pin_out", 64'(pin_out), 64'd0);
    check("t6_rst_pend", 64'(evt_pending), 64'd0);
    check("t6_rst_irq", 64'(irq), 64'd0);
    rst_n = 1'b1;
    tick(4);
    check("t6_rel_e4", 64'(pin_out), 64'd0);
    tick(1);
    check("t6_rel_e5", 64'(pin_out), 64'(ONES));
    check("t6_rel_pend", 64'(evt_pending), 64'(RMASK));
    check("t6_rel_irq0", 64'(irq), 64'd0);
    tick(1);
    check("t6_rel_irq1", 64'(irq), 64'd1);
    pad_in = '0;
    tick(3);
    check("t6_midcount", 64'(pin_out), 64'(ONES));
    rst_n = 1'b0;
    #2;
    check("t6_async_pin_out", 64'(pin_out), 64'd0);
    check("t6_async_pend", 64'(evt_pending), 64'd0);
    check("t6_async_irq", 64'(irq), 64'd0);
    tick(2);
    rst_n  = 1'b1;
    pad_in = ONES;
    tick(4);
    check("t6_restart_e4", 64'(pin_out), 64'd0);
    tick(1);
    check("t6_restart_e5", 64'(pin_out), 64'(ONES));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
